// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache CPU-port arbiter.
//  - state_t    : arbiter FSM encoding (IDLE -> BUSY -> RESP -> IDLE)
//  - M_IFETCH   : master id of the instruction-fetch requester (port m0)
//  - M_LSU      : master id of the load/store requester (port m1)
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_LSU    = 1'b1;

endpackage : cache_arb_pkg

// File: rtl/cache_port_arbiter.sv
// Two-master round-robin arbiter in front of the cache CPU port.
// One transaction in flight: the winner's request is latched on grant, held
// stable to the cache until c_ack, and the response is routed to the winner.
//
// Ports
//  cache_clk, cache_reset      : clock (rising edge), async active-high reset
//  mN_addr/wdata/rd/wr/bval    : master N request (level, held until mN_ack)
//  mN_rdata, mN_ack            : master N response (rdata valid with ack pulse)
//  c_addr/wdata/rd/wr/bval     : registered request to the cache
//  c_rdata, c_ack              : cache response (rdata valid with ack pulse)
//  grant_id                    : master owning the current/last transaction
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_SIZE     = 16,
  parameter int CPU_WORD_SIZE = 32,
  parameter int BVAL_WIDTH    = 4
) (
  input  logic                     cache_clk,
  input  logic                     cache_reset,
  input  logic [ADDR_SIZE-1:0]     m0_addr,
  input  logic [CPU_WORD_SIZE-1:0] m0_wdata,
  input  logic                     m0_rd,
  input  logic                     m0_wr,
  input  logic [BVAL_WIDTH-1:0]    m0_bval,
  output logic [CPU_WORD_SIZE-1:0] m0_rdata,
  output logic                     m0_ack,
  input  logic [ADDR_SIZE-1:0]     m1_addr,
  input  logic [CPU_WORD_SIZE-1:0] m1_wdata,
  input  logic                     m1_rd,
  input  logic                     m1_wr,
  input  logic [BVAL_WIDTH-1:0]    m1_bval,
  output logic [CPU_WORD_SIZE-1:0] m1_rdata,
  output logic                     m1_ack,
  output logic [ADDR_SIZE-1:0]     c_addr,
  output logic [CPU_WORD_SIZE-1:0] c_wdata,
  output logic                     c_rd,
  output logic                     c_wr,
  output logic [BVAL_WIDTH-1:0]    c_bval,
  input  logic [CPU_WORD_SIZE-1:0] c_rdata,
  input  logic                     c_ack,
  output logic                     grant_id
);

  // Master inputs gathered into arrays indexed by master id.
  logic [ADDR_SIZE-1:0]     w_addr  [2];
  logic [CPU_WORD_SIZE-1:0] w_wdata [2];
  logic [BVAL_WIDTH-1:0]    w_bval  [2];
  logic [1:0]               w_rd;
  logic [1:0]               w_wr;
  logic [1:0]               w_req;
  logic                     w_pick;

  state_t                   r_state;
  logic                     r_rr_last;
  logic                     r_grant_id;
  logic [ADDR_SIZE-1:0]     r_c_addr;
  logic [CPU_WORD_SIZE-1:0] r_c_wdata;
  logic [BVAL_WIDTH-1:0]    r_c_bval;
  logic                     r_c_rd;
  logic                     r_c_wr;
  logic [1:0]               r_ack;
  logic [CPU_WORD_SIZE-1:0] r_rdata [2];

  assign w_addr[M_IFETCH]  = m0_addr;
  assign w_addr[M_LSU]     = m1_addr;
  assign w_wdata[M_IFETCH] = m0_wdata;
  assign w_wdata[M_LSU]    = m1_wdata;
  assign w_bval[M_IFETCH]  = m0_bval;
  assign w_bval[M_LSU]     = m1_bval;
  assign w_rd              = {m1_rd, m0_rd};
  assign w_wr              = {m1_wr, m0_wr};
  assign w_req             = w_rd | w_wr;

  // Both asking: the master that did not win last time goes. Otherwise the
  // single requester wins (w_req[1] is 0 when only M0 asks).
  assign w_pick = (&w_req) ? ~r_rr_last : w_req[1];

  always_ff @(posedge cache_clk or posedge cache_reset) begin
    if (cache_reset) begin
      r_state    <= ST_IDLE;
      r_rr_last  <= M_LSU;
      r_grant_id <= M_IFETCH;
      r_c_addr   <= '0;
      r_c_wdata  <= '0;
      r_c_bval   <= '0;
      r_c_rd     <= 1'b0;
      r_c_wr     <= 1'b0;
      r_ack      <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      // Ack is a single-cycle pulse: only ever set on the BUSY->RESP edge.
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_c_addr   <= w_addr[w_pick];
            r_c_wdata  <= w_wdata[w_pick];
            r_c_bval   <= w_bval[w_pick];
            // rd+wr together is illegal; it is executed as a write.
            r_c_wr     <= w_wr[w_pick];
            r_c_rd     <= w_rd[w_pick] & ~w_wr[w_pick];
            r_grant_id <= w_pick;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Request stays frozen until the cache answers; no abort, no timeout.
          if (c_ack) begin
            r_rdata[r_grant_id] <= c_rdata;
            r_ack[r_grant_id]   <= 1'b1;
            r_c_rd              <= 1'b0;
            r_c_wr              <= 1'b0;
            r_rr_last           <= r_grant_id;
            r_state             <= ST_RESP;
          end
        end
        ST_RESP: begin
          // One cycle with request low so the cache controller sees it drop.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign c_addr   = r_c_addr;
  assign c_wdata  = r_c_wdata;
  assign c_bval   = r_c_bval;
  assign c_rd     = r_c_rd;
  assign c_wr     = r_c_wr;
  assign grant_id = r_grant_id;
  assign m0_ack   = r_ack[M_IFETCH];
  assign m1_ack   = r_ack[M_LSU];
  assign m0_rdata = r_rdata[M_IFETCH];
  assign m1_rdata = r_rdata[M_LSU];

endmodule : cache_port_arbiter
